adc_sample_buffer: RTL and testbench

- Downstream consumer of the ADC SPI sequencer.
- Captures the MSB-first serial conversion on sdi while the sequencer asserts reading, then commits the assembled word into a small FIFO when the sequencer pulses write_en.
- Presents buffered samples to the downstream datapath over a valid/ready interface.
- Flags malformed frames and overflows with sticky status bits.

---
 rtl/adc_pkg.sv | 10 +
 rtl/adc_sample_buffer_if.sv | 16 +
 rtl/sample_fifo.sv | 56 +++++
 rtl/adc_sample_buffer.sv | 89 ++++++++
 tb/tb_adc_sample_buffer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample capture path: frame width, buffer depth
// and the sample type carried between the shifter and the downstream FIFO.
package adc_pkg;

   localparam int ADC_DATA_W        = 12;
   localparam int SAMPLE_FIFO_DEPTH = 8;

   typedef logic [ADC_DATA_W-1:0] sample_t;

endpackage

// File: rtl/adc_sample_buffer_if.sv
// Read-side handshake of the sample buffer. rd_data is meaningful only while
// rd_valid=1; a transfer happens on each sck edge where rd_valid && rd_ready.
interface adc_sample_buffer_if
   import adc_pkg::*;
#(
   parameter int DATA_W = ADC_DATA_W
);

   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_ready;

   modport master (output rd_data, output rd_valid, input rd_ready);
   modport slave  (input rd_data, input rd_valid, output rd_ready);

endinterface

// File: rtl/sample_fifo.sv
// Synchronous FIFO with explicit occupancy count; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module sample_fifo #(
   parameter int W     = 12,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          w_push;
   logic          w_pop;

   assign empty  = (r_level == '0);
   assign full   = (r_level == (AW+1)'(DEPTH));
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);

   // Head reads as zero while empty so the output is defined after reset.
   assign dout  = empty ? '0 : r_mem[r_rd_ptr];
   assign level = r_level;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/adc_sample_buffer.sv
// Assembles MSB-first ADC frames from sdi, commits complete frames into the
// sample FIFO on write_en, and keeps sticky overflow / frame-error status.
module adc_sample_buffer
   import adc_pkg::*;
#(
   parameter int DATA_W = ADC_DATA_W,
   parameter int DEPTH  = SAMPLE_FIFO_DEPTH
) (
   input  logic                     sck,
   input  logic                     reset,
   input  logic                     sdi,
   input  logic                     reading,
   input  logic                     write_en,
   input  logic                     clr_status,
   adc_sample_buffer_if.master      rd,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     frame_err
);

   localparam int CW = $clog2(DATA_W + 2);

   logic [DATA_W-1:0] r_shreg;
   logic [CW-1:0]     r_bitcnt;
   logic              r_overflow;
   logic              r_frame_err;

   logic              w_full_frame;
   logic              w_commit;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic              w_set_ovf;
   logic              w_set_ferr;
   logic [DATA_W-1:0] w_dout;

   assign w_full_frame = (r_bitcnt == CW'(DATA_W));
   assign w_commit     = write_en && w_full_frame;
   assign w_pop        = !w_empty && rd.rd_ready;
   assign w_set_ovf    = w_commit && w_full && !w_pop;
   assign w_set_ferr   = write_en && !w_full_frame;

   // bitcnt saturates one past DATA_W so an over-long frame stays distinguishable.
   always_ff @(posedge sck or negedge reset) begin
      if (!reset) begin
         r_shreg  <= '0;
         r_bitcnt <= '0;
      end else if (write_en) begin
         r_bitcnt <= '0;
      end else if (reading) begin
         r_shreg <= {r_shreg[DATA_W-2:0], sdi};
         if (r_bitcnt != CW'(DATA_W + 1)) r_bitcnt <= r_bitcnt + CW'(1);
      end
   end

   // A set condition in the same cycle as clr_status wins.
   always_ff @(posedge sck or negedge reset) begin
      if (!reset) begin
         r_overflow  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_set_ovf)       r_overflow <= 1'b1;
         else if (clr_status) r_overflow <= 1'b0;
         if (w_set_ferr)      r_frame_err <= 1'b1;
         else if (clr_status) r_frame_err <= 1'b0;
      end
   end

   sample_fifo #(
      .W     (DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (sck),
      .rst_n (reset),
      .push  (w_commit),
      .din   (r_shreg),
      .pop   (w_pop),
      .dout  (w_dout),
      .level (level),
      .full  (w_full),
      .empty (w_empty)
   );

   assign rd.rd_data  = w_dout;
   assign rd.rd_valid = !w_empty;
   assign overflow    = r_overflow;
   assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_adc_sample_buffer.sv
// Directed and randomised frames into adc_sample_buffer with a reference model
// and an expected-sample queue compared against every popped and head word.
module tb_adc_sample_buffer;
   import adc_pkg::*;

   localparam int DW = ADC_DATA_W;
   localparam int DP = SAMPLE_FIFO_DEPTH;
   localparam int LW = $clog2(DP) + 1;

   logic          sck = 1'b0;
   logic          reset = 1'b0;
   logic          sdi = 1'b0;
   logic          reading = 1'b0;
   logic          write_en = 1'b0;
   logic          clr_status = 1'b0;
   logic [LW-1:0] level;
   logic          overflow;
   logic          frame_err;

   adc_sample_buffer_if #(.DATA_W(DW)) u_if ();

   adc_sample_buffer #(.DATA_W(DW), .DEPTH(DP)) dut (
      .sck        (sck),
      .reset      (reset),
      .sdi        (sdi),
      .reading    (reading),
      .write_en   (write_en),
      .clr_status (clr_status),
      .rd         (u_if),
      .level      (level),
      .overflow   (overflow),
      .frame_err  (frame_err)
   );

   always #5 sck = ~sck;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [DW-1:0] exp_q[$];
   int            m_level;
   int            m_bitcnt;
   logic [DW-1:0] m_shreg;
   logic          m_ovf;
   logic          m_ferr;
   logic          g_rdy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge sck);
      @(negedge sck);
   endtask

   task automatic model_reset;
      m_level  = 0;
      m_bitcnt = 0;
      m_shreg  = '0;
      m_ovf    = 1'b0;
      m_ferr   = 1'b0;
      exp_q.delete();
   endtask

   task automatic step(input logic rd_i, input logic sd_i, input logic we_i,
                       input logic rdy_i, input logic clr_i);
      logic pop;
      logic pushed;
      logic set_o;
      logic set_f;
      reading       = rd_i;
      sdi           = sd_i;
      write_en      = we_i;
      u_if.rd_ready = rdy_i;
      clr_status    = clr_i;
      pop    = rdy_i && (m_level != 0);
      pushed = 1'b0;
      set_o  = 1'b0;
      set_f  = 1'b0;
      if (pop) begin
         check("pop_data", u_if.rd_data, exp_q[0]);
         void'(exp_q.pop_front());
      end
      if (we_i) begin
         if (m_bitcnt == DW) begin
            if (m_level < DP || pop) begin
               exp_q.push_back(m_shreg);
               pushed = 1'b1;
            end else begin
               set_o = 1'b1;
            end
         end else begin
            set_f = 1'b1;
         end
         m_bitcnt = 0;
      end else if (rd_i) begin
         m_shreg = {m_shreg[DW-2:0], sd_i};
         if (m_bitcnt < DW + 1) m_bitcnt++;
      end
      m_level = m_level + (pushed ? 1 : 0) - (pop ? 1 : 0);
      if (clr_i) begin
         m_ovf  = 1'b0;
         m_ferr = 1'b0;
      end
      if (set_o) m_ovf = 1'b1;
      if (set_f) m_ferr = 1'b1;
      tick();
      check("level", level, m_level);
      check("rd_valid", u_if.rd_valid, m_level != 0);
      check("overflow", overflow, m_ovf);
      check("frame_err", frame_err, m_ferr);
      if (m_level != 0) check("head", u_if.rd_data, exp_q[0]);
   endtask

   task automatic send_bits(input logic [DW-1:0] val, input int nbits);
      for (int i = 0; i < nbits; i++) step(1'b1, val[DW-1-i], 1'b0, g_rdy, 1'b0);
   endtask

   task automatic send_frame(input logic [DW-1:0] val, input int nbits);
      send_bits(val, nbits);
      step(1'b0, 1'b0, 1'b1, g_rdy, 1'b0);
   endtask

   task automatic do_reset;
      reading       = 1'b0;
      write_en      = 1'b0;
      sdi           = 1'b0;
      clr_status    = 1'b0;
      u_if.rd_ready = 1'b0;
      reset         = 1'b0;
      #1;
      model_reset();
      check("rst_level", level, 0);
      check("rst_valid", u_if.rd_valid, 0);
      check("rst_data", u_if.rd_data, 0);
      check("rst_ovf", overflow, 0);
      check("rst_ferr", frame_err, 0);
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic drain;
      for (int i = 0; i < 2 * DP && m_level != 0; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("drained_valid", u_if.rd_valid, 0);
      check("drained_level", level, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      g_rdy         = 1'b0;
      u_if.rd_ready = 1'b0;
      model_reset();
      @(negedge sck);
      do_reset();

      // Single frame 1010_0101_1100
      send_frame(12'hA5C, DW);
      check("t1_data", u_if.rd_data, 12'hA5C);
      check("t1_level", level, 1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t1_empty", u_if.rd_valid, 0);

      // Ordering and pointer wrap
      do_reset();
      g_rdy = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         if (k == 5) g_rdy = 1'b1;
         send_frame(DW'(k), DW);
      end
      drain();
      check("t2_ovf", overflow, 0);

      // Overflow with the 9th word dropped
      do_reset();
      g_rdy = 1'b0;
      for (int k = 1; k <= 9; k++) send_frame(DW'(12'h100 + k), DW);
      check("t3_level", level, DP);
      check("t3_ovf", overflow, 1);
      check("t3_head", u_if.rd_data, 12'h101);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t3_clr", overflow, 0);

      // Push and pop together while full
      send_bits(12'h2AA, DW);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check("t4_level", level, DP);
      check("t4_ovf", overflow, 0);
      check("t4_head", u_if.rd_data, 12'h102);
      drain();

      // Short frame, then set-beats-clear, then a good frame
      do_reset();
      send_frame(12'h155, 10);
      check("t5_ferr", frame_err, 1);
      check("t5_level", level, 0);
      send_bits(12'h0F0, 11);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      check("t5_set_wins", frame_err, 1);
      send_frame(12'hFFF, DW);
      check("t5_data", u_if.rd_data, 12'hFFF);
      check("t5_level2", level, 1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t5_clr", frame_err, 0);
      drain();

      // Reset in the middle of a frame
      do_reset();
      send_bits(12'hABC, 6);
      do_reset();
      send_frame(12'h3C3, DW);
      check("t6_data", u_if.rd_data, 12'h3C3);
      check("t6_level", level, 1);
      check("t6_ferr", frame_err, 0);

      // Random frames, lengths and back-pressure
      do_reset();
      for (int k = 0; k < 30; k++) begin
         g_rdy = 1'($urandom_range(0, 1));
         send_frame(DW'($urandom_range(0, 4095)), ($urandom_range(0, 7) == 0) ? 11 : DW);
         if ($urandom_range(0, 9) == 0) step(1'b0, 1'b0, 1'b0, g_rdy, 1'b1);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
